// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the iterative RV32M multiply/divide unit.
//   op_t      : RV32M funct3 encodings for the M extension
//   state_t   : control FSM states
//   ITER_COUNT: iterations spent in CALC (one product/quotient bit each)
//   DIV0_Q    : quotient returned on divide-by-zero
//   INT_MIN   : most negative 32-bit value (DIV overflow result)
//   op_signs(): which operands an op treats as two's-complement
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] DIV0_Q     = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        WB    = 2'd3
    } state_t;

    typedef struct packed {
        logic a_signed;
        logic b_signed;
    } sign_sel_t;

    // MUL only returns the low word, which is identical for signed and
    // unsigned operands, so it is handled as unsigned.
    function automatic sign_sel_t op_signs(input op_t op);
        sign_sel_t s;
        s.a_signed = (op == OP_MULH) || (op == OP_MULHSU) ||
                     (op == OP_DIV)  || (op == OP_REM);
        s.b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        return s;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration on the {acc, mq} register pair.
//   Multiply (is_div=0): shift-add. If mq[0] is set, m is added to acc; the
//     33-bit sum and mq are then shifted right together, so after W steps
//     {acc, mq} holds the 2W-bit product.
//   Divide (is_div=1): restoring. {acc, mq} shifts left one bit, m is trial-
//     subtracted from the widened partial remainder, and the quotient bit
//     enters mq[0]. After W steps mq is the quotient and acc the remainder.
// Ports:
//   is_div          : select divide iteration
//   acc, mq, m      : partial accumulator/remainder, multiplier/quotient,
//                     multiplicand/divisor magnitudes
//   acc_next, mq_next: updated register pair
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] mq,
    input  logic [DATA_WIDTH-1:0] m,
    output logic [DATA_WIDTH-1:0] acc_next,
    output logic [DATA_WIDTH-1:0] mq_next
);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, m};
        shifted  = {acc, mq[DATA_WIDTH-1]};
        // The partial remainder stays below 2*m, so the top bit of the
        // difference is set exactly when the trial subtraction borrows.
        diff     = shifted - {1'b0, m};
        acc_next = acc;
        mq_next  = mq;

        if (is_div) begin
            if (!diff[DATA_WIDTH]) begin
                acc_next = diff[DATA_WIDTH-1:0];
                mq_next  = {mq[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted[DATA_WIDTH-1:0];
                mq_next  = {mq[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            if (mq[0]) begin
                {acc_next, mq_next} = {sum, mq[DATA_WIDTH-1:1]};
            end else begin
                {acc_next, mq_next} = {1'b0, acc, mq[DATA_WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit acting as a second writer on the
// register file's WE3/AD3/WD3 port. Every op takes the same number of cycles:
// accept, 32 CALC iterations, one FIXUP (sign/special-case correction and
// result capture), then a single WB cycle.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request; only accepted in IDLE
//   op              : RV32M funct3
//   src_a, src_b    : rs1/rs2 values
//   rd_addr         : destination register
//   kill            : abort in-flight op (ignored in IDLE)
//   busy            : unit is not IDLE
//   done            : one-cycle pulse in WB (also for rd=x0)
//   WE3, AD3, WD3   : register-file write port; AD3/WD3 hold outside WB
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int REG_FILE_ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [2:0]                     op,
    input  logic [DATA_WIDTH-1:0]          src_a,
    input  logic [DATA_WIDTH-1:0]          src_b,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr,
    input  logic                           kill,
    output logic                           busy,
    output logic                           done,
    output logic                           WE3,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
    output logic [DATA_WIDTH-1:0]          WD3
);

    localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

    state_t                         state_q, state_d;
    logic [4:0]                     cnt_q;
    op_t                            op_q;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_q;
    logic                           a_neg_q, b_neg_q, b_zero_q;
    logic [DATA_WIDTH-1:0]          acc_q, mq_q, m_q;
    logic [DATA_WIDTH-1:0]          acc_nx, mq_nx;
    logic [REG_FILE_ADDR_WIDTH-1:0] ad3_q;
    logic [DATA_WIDTH-1:0]          wd3_q;

    logic                           accept;
    sign_sel_t                      signs;
    logic                           a_neg, b_neg;
    logic [DATA_WIDTH-1:0]          a_mag, b_mag;

    logic [2*DATA_WIDTH-1:0]        prod, prod_fix;
    logic [DATA_WIDTH-1:0]          quo_fix, rem_fix, result;

    // ---------------------------------------------------------------- control
    assign accept = (state_q == IDLE) && start;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == LAST_ITER) state_d = FIXUP;
            FIXUP:   state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // kill has no effect in IDLE, so a coincident start still wins.
        if (kill && (state_q != IDLE)) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == WB);
    // kill in WB must suppress the write in the same cycle, hence the
    // combinational gate rather than a registered enable.
    assign WE3  = done && (ad3_q != '0) && !kill;
    assign AD3  = ad3_q;
    assign WD3  = wd3_q;

    // ------------------------------------------------------- operand capture
    always_comb begin
        signs = op_signs(op_t'(op));
        a_neg = signs.a_signed && src_a[DATA_WIDTH-1];
        b_neg = signs.b_signed && src_b[DATA_WIDTH-1];
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;
    end

    // ------------------------------------------------------------- iteration
    muldiv_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .is_div   (op_q[2]),
        .acc      (acc_q),
        .mq       (mq_q),
        .m        (m_q),
        .acc_next (acc_nx),
        .mq_next  (mq_nx)
    );

    // ----------------------------------------------------------------- fixup
    // Signed overflow (INT_MIN / -1) needs no special path: the magnitudes
    // give quotient 0x80000000, whose negation is itself, and remainder 0.
    // A zero divisor makes every trial subtraction succeed, leaving all-ones
    // in mq and |a| in acc; restoring sign(a) on acc reproduces src_a for REM.
    always_comb begin
        prod     = {acc_q, mq_q};
        prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
        quo_fix  = (a_neg_q ^ b_neg_q) ? -mq_q : mq_q;
        rem_fix  = a_neg_q ? -acc_q : acc_q;
        result   = '0;
        unique case (op_q)
            OP_MUL:                       result = prod_fix[DATA_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV, OP_DIVU:              result = b_zero_q ? DIV0_Q : quo_fix;
            OP_REM, OP_REMU:              result = rem_fix;
            default:                      result = '0;
        endcase
    end

    // -------------------------------------------------------------- datapath
    // NOTE: the datapath registers are few and cheap, so they all take the
    // async reset; this keeps AD3/WD3 and the operand state deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            rd_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            acc_q    <= '0;
            mq_q     <= '0;
            m_q      <= '0;
            ad3_q    <= '0;
            wd3_q    <= '0;
        end else begin
            if (accept) begin
                cnt_q    <= '0;
                op_q     <= op_t'(op);
                rd_q     <= rd_addr;
                a_neg_q  <= a_neg;
                b_neg_q  <= b_neg;
                b_zero_q <= (src_b == '0);
                acc_q    <= '0;
                mq_q     <= a_mag;
                m_q      <= b_mag;
            end else if ((state_q == CALC) && !kill) begin
                cnt_q <= cnt_q + 5'd1;
                acc_q <= acc_nx;
                mq_q  <= mq_nx;
            end

            // The result port only changes when a writeback is about to
            // happen; a killed op leaves the previous values in place.
            if ((state_q == FIXUP) && !kill) begin
                ad3_q <= rd_q;
                wd3_q <= result;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit: each accepted request pushes its expected
// writeback (from a behavioural RV32M model) and due cycle; a monitor pops an
// entry on every done pulse and compares latency, WE3, AD3 and WD3.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int LATENCY = 33;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          kill = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  src_a = '0;
    logic [W-1:0]  src_b = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          busy, done, WE3;
    logic [AW-1:0] AD3;
    logic [W-1:0]  WD3;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] rd;
        logic [W-1:0]  data;
        int unsigned   due;
    } exp_t;

    exp_t sb_q[$];

    muldiv_unit #(
        .DATA_WIDTH          (W),
        .REG_FILE_ADDR_WIDTH (AW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .rd_addr (rd_addr),
        .kill    (kill),
        .busy    (busy),
        .done    (done),
        .WE3     (WE3),
        .AD3     (AD3),
        .WD3     (WD3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    // Behavioural RV32M reference.
    function automatic logic [W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic signed [63:0] sa64, sb64, p_ss, p_su;
        logic        [63:0] p_uu;
        logic signed [31:0] sa, sb, q, r;
        logic               ovf;
        sa   = a;
        sb   = b;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        p_ss = sa64 * sb64;
        p_su = sa64 * $signed({32'd0, b});
        p_uu = {32'd0, a} * {32'd0, b};
        ovf  = (a == INT_MIN) && (b == 32'hFFFF_FFFF);
        q    = (b == 0 || ovf) ? 32'sd0 : sa / sb;
        r    = (b == 0 || ovf) ? 32'sd0 : sa % sb;
        case (o)
            3'b000:  return p_uu[31:0];
            3'b001:  return p_ss[63:32];
            3'b010:  return p_su[63:32];
            3'b011:  return p_uu[63:32];
            3'b100:  return (b == 0) ? DIV0_Q : (ovf ? INT_MIN : q);
            3'b101:  return (b == 0) ? DIV0_Q : a / b;
            3'b110:  return (b == 0) ? a : (ovf ? 32'd0 : r);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done_entries", 64'(sb_q.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("wb_latency", 64'(cyc), 64'(e.due));
                    check("we3", 64'(WE3), 64'(e.we));
                    if (e.we) begin
                        check("ad3", 64'(AD3), 64'(e.rd));
                        check("wd3", 64'(WD3), 64'(e.data));
                    end
                end
            end else if (WE3) begin
                check("we3_without_done", 64'(WE3), 64'd0);
            end
        end
    end

    // Drive one request; with expect_wb the scoreboard gets its entry.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] rd, input bit expect_wb);
        exp_t e;
        @(negedge clk);
        op = o; src_a = a; src_b = b; rd_addr = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        if (expect_wb) begin
            e.we   = (rd != 0);
            e.rd   = rd;
            e.data = ref_result(o, a, b);
            e.due  = cyc + LATENCY;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || sb_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 64'(busy || (sb_q.size() != 0)), 64'd0);
        sb_q.delete();
    endtask

    task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] rd, input string tag);
        issue(o, a, b, rd, 1'b1);
        wait_idle(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_we3",  64'(WE3),  64'd0);
        check("rst_ad3",  64'(AD3),  64'd0);
        check("rst_wd3",  64'(WD3),  64'd0);
        rst_n = 1'b1;

        // Basic multiply and the hold behaviour of AD3/WD3.
        run(OP_MUL, 32'd7, -32'sd3, 5'd5, "mul");
        check("ad3_hold", 64'(AD3), 64'd5);
        check("wd3_hold", 64'(WD3), 64'hFFFF_FFEB);

        run(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, "mulhu");
        run(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulh");
        run(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd3, "mulhsu");
        run(OP_DIV,    -32'sd7,       32'd2,         5'd4, "div");
        run(OP_REM,    -32'sd7,       32'd2,         5'd6, "rem");
        run(OP_DIVU,   32'd100,       32'd7,         5'd8, "divu");
        run(OP_REMU,   32'd100,       32'd7,         5'd9, "remu");

        // Divide by zero and signed overflow keep the standard latency.
        run(OP_DIVU, 32'd5,   32'd0,         5'd10, "divu_zero");
        run(OP_REM,  32'd5,   32'd0,         5'd11, "rem_zero");
        run(OP_DIV,  -32'sd9, 32'd0,         5'd12, "div_neg_zero");
        run(OP_REM,  -32'sd9, 32'd0,         5'd13, "rem_neg_zero");
        run(OP_DIV,  INT_MIN, 32'hFFFF_FFFF, 5'd14, "div_ovf");
        run(OP_REM,  INT_MIN, 32'hFFFF_FFFF, 5'd15, "rem_ovf");

        // A second start while busy is dropped: one writeback to rd 7 only.
        issue(OP_MUL, 32'd6, 32'd7, 5'd7, 1'b1);
        repeat (5) @(negedge clk);
        op = OP_DIVU; src_a = 32'd50; src_b = 32'd5; rd_addr = 5'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("ignored_start");
        repeat (3) @(negedge clk);
        check("ignored_start_ad3", 64'(AD3), 64'd7);
        check("ignored_start_busy", 64'(busy), 64'd0);

        // kill mid-CALC: idle right after the kill edge, no writeback later.
        issue(OP_DIV, 32'd1234, 32'd7, 5'd20, 1'b0);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("kill_ad3_unchanged", 64'(AD3), 64'd7);
        check("kill_wd3_unchanged", 64'(WD3), 64'd42);

        // start coincident with kill in IDLE is still accepted.
        @(negedge clk);
        kill = 1'b1;
        issue(OP_MULHU, 32'h8000_0000, 32'd4, 5'd21, 1'b1);
        kill = 1'b0;
        wait_idle("start_with_kill");

        // Write to x0: done pulses, WE3 stays low.
        run(OP_MUL, 32'd9, 32'd9, 5'd0, "rd_zero");

        // Asynchronous reset mid-operation.
        issue(OP_DIV, 32'd1000, 32'd3, 5'd4, 1'b0);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_we3",  64'(WE3),  64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(OP_MUL, 32'd3, 32'd4, 5'd6, "mul_after_rst");

        // Random mix over all ops, with occasional zero divisors.
        for (int i = 0; i < 16; i++) begin
            logic [2:0]    ro;
            logic [W-1:0]  ra, rb;
            logic [AW-1:0] rr;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (i == 3) rb = 32'd1 + 32'($urandom_range(0, 9));
            rr = 5'($urandom_range(1, 31));
            run(ro, ra, rb, rr, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
